// File: rtl/uart_tx.sv
// Serial UART transmitter: valid/ready word intake, then start bit, LSB-first data,
// optional parity and stop bit(s) on a single registered line that idles high.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned BITS_N       = 8,
  parameter int unsigned PARITY_TYPE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BITS_N-1:0] data_tx,
  input  logic              valid,
  output logic              tx_ready,
  output logic              uart_out
);

  localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(BITS_N + 1);

  localparam logic [CLK_W-1:0] LAST_CLK  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(BITS_N - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY_TYPE == 1);
  localparam bit               HAS_PAR   = (PARITY_TYPE != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state_q,    state_d;
  logic [CLK_W-1:0]   clk_cnt_q,  clk_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [BITS_N-1:0]  shreg_q,    shreg_d;
  logic               parity_q,   parity_d;
  logic               uart_out_q, uart_out_d;
  logic               tx_ready_q, tx_ready_d;
  logic               bit_end;

  assign bit_end  = (clk_cnt_q == LAST_CLK);
  assign uart_out = uart_out_q;
  assign tx_ready = tx_ready_q;

  // Next-state logic also computes the next line level, so both outputs leave a flop.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + CLK_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    uart_out_d = uart_out_q;
    tx_ready_d = tx_ready_q;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
        uart_out_d = 1'b1;
        tx_ready_d = 1'b1;
        if (valid && tx_ready_q) begin
          state_d    = START;
          shreg_d    = data_tx;
          parity_d   = (^data_tx) ^ ODD_PAR;
          uart_out_d = 1'b0;
          tx_ready_d = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d    = DATA;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          uart_out_d = shreg_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (HAS_PAR) begin
              state_d    = PARITY;
              uart_out_d = parity_q;
            end else begin
              state_d    = STOP;
              uart_out_d = 1'b1;
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            shreg_d    = shreg_q >> 1;
            uart_out_d = shreg_q[1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          uart_out_d = 1'b1;
        end
      end

      STOP: begin
        // The bit counter tallies stop bits, so the clock counter never exceeds one bit time.
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == LAST_STOP) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            tx_ready_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d    = IDLE;
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
        uart_out_d = 1'b1;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      // NOTE: the data path is reset too; it is small and keeps post-reset state deterministic.
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      uart_out_q <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      uart_out_q <= uart_out_d;
      tx_ready_q <= tx_ready_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a default 8N1 instance and an 8E2 instance,
// each frame compared cycle by cycle against a bit-level model of the line.
module tb_uart_tx;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_tx;
  logic       valid, valid_p;
  logic       tx_ready, uart_out;
  logic       tx_ready_p, uart_out_p;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx dut (
    .clk      (clk),
    .reset    (reset),
    .data_tx  (data_tx),
    .valid    (valid),
    .tx_ready (tx_ready),
    .uart_out (uart_out)
  );

  uart_tx #(.PARITY_TYPE(2), .STOP_BITS(2)) dut_p (
    .clk      (clk),
    .reset    (reset),
    .data_tx  (data_tx),
    .valid    (valid_p),
    .tx_ready (tx_ready_p),
    .uart_out (uart_out_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line level during bit slot j of a frame carrying d: start, 8 data bits, parity, stops.
  function automatic logic exp_level(input logic [7:0] d, input int par, input int j);
    int ones;
    ones = $countones(d);
    if (j == 0) return 1'b0;
    if (j <= 8) return ((int'(d) >> (j - 1)) & 1) == 1;
    if (par != 0 && j == 9) return (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  task automatic drive_valid(input bit sel, input logic v);
    if (sel) valid_p = v;
    else     valid   = v;
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? uart_out_p : uart_out;
  endfunction

  function automatic logic ready_of(input bit sel);
    return sel ? tx_ready_p : tx_ready;
  endfunction

  // Called at a negedge with the DUT idle. mode: 0 = 1-cycle valid, 1 = inject a
  // busy-time request of 8'hFF, 2 = keep valid high for a back-to-back follow-up.
  // abort_at >= 0 pulls reset at that cycle offset and checks the immediate response.
  task automatic send_frame(input bit sel, input logic [7:0] d, input int par, input int stops,
                            input string tag, input int mode, input int abort_at);
    int   f, j, line_err, rdy_err;
    logic line, rdy, pbit;
    logic [7:0] rx;
    f = (1 + 8 + ((par != 0) ? 1 : 0) + stops) * CPB;
    line_err = 0; rdy_err = 0; rx = '0; pbit = 1'b0;
    data_tx = d;
    drive_valid(sel, 1'b1);
    @(posedge clk);
    for (int k = 0; k <= f; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (mode != 2) drive_valid(sel, 1'b0);
        data_tx = 8'($urandom);
      end
      line = line_of(sel);
      rdy  = ready_of(sel);
      if (k < f) begin
        j = k / CPB;
        if (line !== exp_level(d, par, j)) line_err++;
        if (rdy !== 1'b0) rdy_err++;
        if (k % CPB == CPB / 2) begin
          if (j >= 1 && j <= 8 && line) rx = rx | 8'(1 << (j - 1));
          if (j == 9) pbit = line;
        end
      end else begin
        check({tag, "_ready_at_F"}, rdy, 1'b1);
        check({tag, "_line_at_F"}, line, 1'b1);
      end
      if (k == abort_at) begin
        check({tag, "_pre_abort_line_errs"}, line_err, 0);
        reset = 1'b0;
        #1;
        check({tag, "_abort_line"}, line_of(sel), 1'b1);
        check({tag, "_abort_ready"}, ready_of(sel), 1'b1);
        return;
      end
      if (mode == 1 && k == f / 2) begin
        data_tx = 8'hFF;
        drive_valid(sel, 1'b1);
      end
      if (mode == 1 && k == f / 2 + 8) drive_valid(sel, 1'b0);
    end
    check({tag, "_line_errs"}, line_err, 0);
    check({tag, "_ready_low_errs"}, rdy_err, 0);
    check({tag, "_rx_data"}, rx, d);
    if (par != 0) check({tag, "_parity"}, pbit, exp_level(d, par, 9));
  endtask

  task automatic idle_check(input bit sel, input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (line_of(sel) !== 1'b1 || ready_of(sel) !== 1'b1) bad++;
    end
    check({tag, "_idle_errs"}, bad, 0);
  endtask

  task automatic wait_ready(input bit sel, input string tag, input int budget);
    int n;
    n = 0;
    while (ready_of(sel) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_timeout"}, ready_of(sel), 1'b1);
  endtask

  initial begin
    int t3_start;
    reset = 1'b0; valid = 1'b0; valid_p = 1'b0; data_tx = '0;

    // 1: reset held five cycles, outputs idle during and after
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_line", uart_out, 1'b1);
      check("rst_ready", tx_ready, 1'b1);
    end
    check("rst_line_p", uart_out_p, 1'b1);
    check("rst_ready_p", tx_ready_p, 1'b1);
    reset = 1'b1;
    idle_check(1'b0, "post_rst", 3);
    idle_check(1'b1, "post_rst_p", 1);

    // 2: fixed pattern
    send_frame(1'b0, 8'hA5, 0, 1, "a5", 0, -1);

    // 3: random bytes with idle gaps under a cycle budget
    t3_start = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_ready(1'b0, "rnd", 2 * 12 * CPB);
      repeat (10) @(negedge clk);
      send_frame(1'b0, 8'($urandom), 0, 1, $sformatf("rnd%0d", i), 0, -1);
    end
    check("rnd_budget", (cyc - t3_start) < 5 * 12 * CPB * 2, 1'b1);

    // 4: request during a busy frame is dropped
    repeat (3) @(negedge clk);
    send_frame(1'b0, 8'h00, 0, 1, "busy", 1, -1);
    idle_check(1'b0, "busy_after", 2 * CPB);

    // back-to-back with valid held high across the ready rise
    send_frame(1'b0, 8'h96, 0, 1, "b2b_a", 2, -1);
    send_frame(1'b0, 8'h69, 0, 1, "b2b_b", 0, -1);

    // 5: asynchronous abort inside the data bits, then a clean frame
    repeat (4) @(negedge clk);
    send_frame(1'b0, 8'h3C, 0, 1, "abort", 0, 7 * CPB + 10);
    idle_check(1'b0, "abort_hold", 3);
    reset = 1'b1;
    idle_check(1'b0, "abort_release", 5);
    send_frame(1'b0, 8'h55, 0, 1, "after_abort", 0, -1);

    // 6: even parity, two stop bits
    wait_ready(1'b1, "par", 10);
    send_frame(1'b1, 8'h07, 2, 2, "par07", 0, -1);
    send_frame(1'b1, 8'($urandom), 2, 2, "par_rnd", 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
